j1_boot_loader: RTL and testbench
=================================

J1_BOOT_LOADER -- requirements
Module: j1_boot_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter MAX_WORDS, default 8192, program RAM depth in 16-bit words.
REQ-003 Parameter TIMEOUT, default 1_000_000, maximum idle cycles between accepted bytes inside a frame.
REQ-004 sys_clk_i  in  1  single clock; all logic on rising edge.
REQ-005 sys_rst_i  in  1  synchronous, active-high reset.
REQ-006 rx_data  in  8  byte from serial receiver.
REQ-007 rx_valid  in  1  rx_data valid.
REQ-008 rx_ready  out  1  loader accepts the byte; a byte transfers when rx_valid && rx_ready.
REQ-009 boot_req  in  1  single-cycle pulse; halts the CPU and restarts loading.
REQ-010 ram_addr  out  13  program RAM word address.
REQ-011 ram_data  out  16  program RAM write data.
REQ-012 ram_we  out  1  program RAM write strobe, one cycle per word.
REQ-013 cpu_rst_o  out  1  holds the J1 CPU in reset while high.
REQ-014 boot_done  out  1  high while the CPU runs a verified image.
REQ-015 boot_err  out  1  sticky error flag.

Function
REQ-016 Frame format SHALL be: SYNC_BYTE, LEN_HI, LEN_LO (word count N), N words sent high byte first, then a CHK byte equal to the XOR of all 2N data bytes.
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN.
REQ-018 rx_ready SHALL be 1 in every state except RUN; it is 0 in RUN.
REQ-019 IDLE: a byte equal to SYNC_BYTE goes to LEN_HI and clears boot_err; any other byte is discarded.
REQ-020 LEN_HI -> LEN_LO on an accepted byte; LEN_LO -> DATA_HI if N != 0, or CHECK if N == 0.
REQ-021 N > MAX_WORDS: set boot_err and return to IDLE after LEN_LO, with no RAM writes.
REQ-022 DATA_HI latches the high byte -> DATA_LO; DATA_LO completes the word.
REQ-023 Word write: in the cycle after the DATA_LO byte is accepted, ram_we=1, ram_data={hi,lo}, ram_addr=word index (first word at 0).
  - Word index increments after each write.
  - After word N-1 go to CHECK, otherwise back to DATA_HI.
REQ-024 The running XOR SHALL be cleared on leaving IDLE and updated with each accepted data byte only; SYNC, LEN and CHK bytes are excluded.
REQ-025 CHECK, accepted byte equals running XOR: go to RUN; cpu_rst_o=0 and boot_done=1 from the following cycle.
REQ-026 CHECK, mismatch: set boot_err, go to IDLE, and keep cpu_rst_o=1.
REQ-027 Timeout counter:
  - cleared on every accepted byte and whenever the state is IDLE or RUN;
  - counts up in LEN_HI..CHECK;
  - on reaching TIMEOUT-1: set boot_err, go to IDLE.
REQ-028 boot_req in any state: go to IDLE next cycle; cpu_rst_o=1, boot_done=0, word index and XOR cleared, boot_err unchanged.
REQ-029 boot_req coincident with a byte handshake: boot_req wins and the byte is dropped.
REQ-030 A DATA_LO handshake coincident with boot_req SHALL still not produce a write.
REQ-031 In RUN, rx input SHALL be ignored; the loader remains in RUN until boot_req or sys_rst_i.
REQ-032 ram_addr and ram_data SHALL hold their last values when ram_we=0.

Reset
REQ-033 On sys_rst_i: state=IDLE, cpu_rst_o=1, boot_done=0, boot_err=0, ram_we=0, ram_addr=0, ram_data=0, word index=0, XOR=0, timeout counter=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; RAM words already written are not reverted.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Load A5 00 02 12 34 AB CD 40: writes 1234@0, then ABCD@1; cpu_rst_o falls one cycle after byte 40; boot_done=1.
REQ-037 Same frame with CHK=41: two writes occur, boot_err=1, cpu_rst_o stays 1, state IDLE; a following good frame clears boot_err and boots.
REQ-038 A5 00 00 00: no writes, boot completes; A5 20 01: boot_err=1, no writes (8193 > MAX_WORDS).
REQ-039 With TIMEOUT=16, send A5 00 01 12 then stall: boot_err set 16 cycles after the 12 byte; the next A5 restarts the frame.
REQ-040 Backpressure and restart:
  - rx_valid held in RUN gives rx_ready=0 and no writes.
  - boot_req in RUN gives cpu_rst_o=1 and boot_done=0 the next cycle, and rx_ready=1.
REQ-041 sys_rst_i asserted between DATA_HI and DATA_LO: no write for the partial word, and all outputs at their reset values.

Source files
------------

// File: rtl/j1_boot_loader_if.sv
// j1_boot_loader_if
// Groups the loader's byte stream and program-RAM write bus.
//   rx_data/rx_valid : byte stream from the serial receiver into the loader
//   rx_ready         : loader accepts the byte (transfer on rx_valid && rx_ready)
//   ram_addr/ram_data/ram_we : program RAM word write port driven by the loader
// Modport master is the loader side, slave is the receiver/RAM side.
interface j1_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [12:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, ram_addr, ram_data, ram_we
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/j1_boot_loader.sv
// j1_boot_loader
// Receives a framed program image over a byte stream, writes it into the J1
// program RAM and releases the CPU from reset once the XOR checksum matches.
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, N words (high byte first), CHK.
// Ports:
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   boot_req             : pulse; halts the CPU and restarts loading
//   bus (master)         : rx byte stream in, program RAM write port out
//   cpu_rst_o            : holds the CPU in reset while high
//   boot_done            : CPU running a verified image
//   boot_err             : sticky error (bad length, checksum, timeout)
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for SYNC_BYTE, other bytes discarded
// LEN_HI  | expecting word count high byte
// LEN_LO  | expecting word count low byte, range check
// DATA_HI | expecting high byte of the next word
// DATA_LO | expecting low byte; word written on the next cycle
// CHECK   | expecting checksum byte
// RUN     | image verified, CPU released, rx stream ignored
module j1_boot_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_WORDS = 8192,
  parameter int         TIMEOUT   = 1_000_000
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic               boot_req,
  j1_boot_loader_if.master   bus,
  output logic               cpu_rst_o,
  output logic               boot_done,
  output logic               boot_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]   MAX_N    = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ready_d, we_d, cpu_rst_d, done_d, err_d;
  logic [12:0]   addr_d;
  logic [15:0]   data_d;

  logic          accept;
  logic          in_frame;
  logic [15:0]   len_full;

  assign accept   = bus.rx_valid && bus.rx_ready;
  assign in_frame = (state_q != IDLE) && (state_q != RUN);
  assign len_full = {len_q[15:8], bus.rx_data};

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      hi_q         <= '0;
      idx_q        <= '0;
      xor_q        <= '0;
      tmo_q        <= '0;
      bus.rx_ready <= 1'b1;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_data <= '0;
      cpu_rst_o    <= 1'b1;
      boot_done    <= 1'b0;
      boot_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      idx_q        <= idx_d;
      xor_q        <= xor_d;
      tmo_q        <= tmo_d;
      bus.rx_ready <= ready_d;
      bus.ram_we   <= we_d;
      bus.ram_addr <= addr_d;
      bus.ram_data <= data_d;
      cpu_rst_o    <= cpu_rst_d;
      boot_done    <= done_d;
      boot_err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    we_d      = 1'b0;
    addr_d    = bus.ram_addr;
    data_d    = bus.ram_data;
    cpu_rst_d = cpu_rst_o;
    done_d    = boot_done;
    err_d     = boot_err;

    if (!in_frame || accept) tmo_d = '0;
    else                     tmo_d = tmo_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept && bus.rx_data == SYNC_BYTE) begin
          state_d = LEN_HI;
          err_d   = 1'b0;
          xor_d   = '0;
          idx_d   = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.rx_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (len_full > MAX_N) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (len_full == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hi_d    = bus.rx_data;
          xor_d   = xor_q ^ bus.rx_data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = idx_q[12:0];
          data_d  = {hi_q, bus.rx_data};
          xor_d   = xor_q ^ bus.rx_data;
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q == len_q - 16'd1) ? CHECK : DATA_HI;
        end
      end
      CHECK: begin
        if (accept) begin
          if (bus.rx_data == xor_q) begin
            state_d   = RUN;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RUN: ;
      default: state_d = IDLE;
    endcase

    // An accepted byte resets the idle timer, so expiry only fires on a stall.
    if (in_frame && !accept && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end

    // boot_req overrides everything, including a coincident byte or word write.
    if (boot_req) begin
      state_d   = IDLE;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      idx_d     = '0;
      xor_d     = '0;
      tmo_d     = '0;
      we_d      = 1'b0;
      addr_d    = bus.ram_addr;
      data_d    = bus.ram_data;
      err_d     = boot_err;
    end

    ready_d = (state_d != RUN);
  end

endmodule

// File: tb/tb_j1_boot_loader.sv
module tb_j1_boot_loader;

  logic clk;
  logic rst;
  logic boot_req;
  logic cpu_rst_o, boot_done, boot_err;

  j1_boot_loader_if bus();

  j1_boot_loader #(
    .SYNC_BYTE (8'hA5),
    .MAX_WORDS (8192),
    .TIMEOUT   (16)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .boot_req  (boot_req),
    .bus       (bus),
    .cpu_rst_o (cpu_rst_o),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [28:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [12:0] a, input logic [15:0] d);
    sb.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_req = 1'b0);
    int n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    boot_req     = with_req;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_val("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    boot_req     = 1'b0;
  endtask

  task automatic pulse_boot_req();
    @(negedge clk);
    boot_req = 1'b1;
    @(posedge clk);
    #1;
    boot_req = 1'b0;
  endtask

  // Scoreboard: every RAM write must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_write", 32'(bus.ram_we), 32'd0);
      end else begin
        logic [28:0] e;
        e = sb.pop_front();
        check_val("ram_addr", 32'(bus.ram_addr), 32'(e[28:16]));
        check_val("ram_data", 32'(bus.ram_data), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    boot_req     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_val("rst_done", 32'(boot_done), 32'd0);
    check_val("rst_err", 32'(boot_err), 32'd0);
    check_val("rst_we", 32'(bus.ram_we), 32'd0);
    check_val("rst_addr", 32'(bus.ram_addr), 32'd0);
    check_val("rst_data", 32'(bus.ram_data), 32'd0);
    check_val("rst_ready", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Good two-word frame
    push_wr(13'd0, 16'h1234);
    push_wr(13'd1, 16'hABCD);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    check_val("cpu_rst_before_chk", 32'(cpu_rst_o), 32'd1);
    send_byte(8'h40);
    check_val("good_cpu_rst", 32'(cpu_rst_o), 32'd0);
    check_val("good_done", 32'(boot_done), 32'd1);
    check_val("good_err", 32'(boot_err), 32'd0);
    check_val("run_ready", 32'(bus.rx_ready), 32'd0);

    // Valid held in RUN: no acceptance, no writes
    @(negedge clk);
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check_val("run_backpressure", 32'(bus.rx_ready), 32'd0);
    end
    check_val("run_stays_done", 32'(boot_done), 32'd1);
    bus.rx_valid = 1'b0;
    pulse_boot_req();
    check_val("req_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_val("req_done", 32'(boot_done), 32'd0);
    check_val("req_ready", 32'(bus.rx_ready), 32'd1);

    // Reset between DATA_HI and DATA_LO
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h55);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_val("midrst_done", 32'(boot_done), 32'd0);
    check_val("midrst_err", 32'(boot_err), 32'd0);
    check_val("midrst_we", 32'(bus.ram_we), 32'd0);
    check_val("midrst_addr", 32'(bus.ram_addr), 32'd0);
    check_val("midrst_data", 32'(bus.ram_data), 32'd0);
    check_val("midrst_ready", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Bad checksum, then a good frame clears the error
    push_wr(13'd0, 16'h1234);
    push_wr(13'd1, 16'hABCD);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h41);
    check_val("badchk_err", 32'(boot_err), 32'd1);
    check_val("badchk_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_val("badchk_done", 32'(boot_done), 32'd0);
    check_val("badchk_ready", 32'(bus.rx_ready), 32'd1);
    send_byte(8'hA5);
    check_val("sync_clears_err", 32'(boot_err), 32'd0);
    push_wr(13'd0, 16'hBEEF);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h51);
    check_val("reboot_done", 32'(boot_done), 32'd1);
    check_val("reboot_cpu_rst", 32'(cpu_rst_o), 32'd0);
    pulse_boot_req();

    // boot_req coincident with DATA_LO byte: no write, back to IDLE
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
    send_byte(8'h88, 1'b1);
    check_val("reqlo_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_val("reqlo_ready", 32'(bus.rx_ready), 32'd1);
    push_wr(13'd0, 16'h0102);
    send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03);
    check_val("reqlo_reboot_done", 32'(boot_done), 32'd1);
    pulse_boot_req();

    // Zero-length image boots; oversized length errors
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_val("zero_len_done", 32'(boot_done), 32'd1);
    check_val("zero_len_err", 32'(boot_err), 32'd0);
    pulse_boot_req();
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h01);
    check_val("len_big_err", 32'(boot_err), 32'd1);
    check_val("len_big_done", 32'(boot_done), 32'd0);
    check_val("len_big_ready", 32'(bus.rx_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check_val("len_big_err_sticky", 32'(boot_err), 32'd1);

    // Timeout: error exactly 16 cycles after the last accepted byte
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    repeat (15) @(posedge clk);
    #1;
    check_val("tmo_not_yet", 32'(boot_err), 32'd0);
    @(posedge clk);
    #1;
    check_val("tmo_err", 32'(boot_err), 32'd1);
    check_val("tmo_ready", 32'(bus.rx_ready), 32'd1);
    push_wr(13'd0, 16'h1234);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h26);
    check_val("tmo_restart_done", 32'(boot_done), 32'd1);
    check_val("tmo_restart_err", 32'(boot_err), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
